// File: rtl/hilo_muldiv_pkg.sv
// Shared op codes, state encoding and helpers for the HI/LO mul/div unit.
package hilo_muldiv_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   localparam int MD_ITERS = 32;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

   // 0x80000000 maps to itself and is then read as unsigned
   function automatic logic [31:0] md_abs(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Controller-side handshake and HI/LO readout bundle.
interface hilo_muldiv_if;

   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic        done;
   logic [31:0] HI_data;
   logic [31:0] LO_data;

   modport master (
      output start, op, rs_data, rt_data,
      input  busy, done, HI_data, LO_data
   );

   modport slave (
      input  start, op, rs_data, rt_data,
      output busy, done, HI_data, LO_data
   );

endinterface

// File: rtl/hilo_muldiv.sv
// Iterative 32-cycle multiply/divide unit owning the HI and LO registers.
module hilo_muldiv
   import hilo_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst,
   hilo_muldiv_if.slave   md
);

   md_state_e            state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opd_q, opd_d;
   logic [WIDTH-1:0]     rs_q, rs_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 div_q, div_d;
   logic                 neg_q, neg_d;
   logic                 rneg_q, rneg_d;
   logic                 dz_q, dz_d;
   logic                 done_q, done_d;

   logic [32:0] mul_sum;
   logic [63:0] mul_nxt;
   logic [64:0] div_sh;
   logic [32:0] div_trial;
   logic [63:0] div_nxt;
   logic [63:0] prod_fix;
   logic        is_signed;
   logic        is_div;

   // Shared working register: {rem | prod-hi, quot | prod-lo}
   assign mul_sum   = {1'b0, acc_q[63:32]}
                    + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
   assign mul_nxt   = {mul_sum, acc_q[31:1]};
   assign div_sh    = {acc_q, 1'b0};
   assign div_trial = div_sh[64:32] - {1'b0, opd_q};
   assign div_nxt   = div_trial[32] ? div_sh[63:0]
                    : {div_trial[31:0], div_sh[31:1], 1'b1};
   assign prod_fix  = neg_q ? (64'd0 - acc_q) : acc_q;

   assign is_signed = (md.op == MD_MULT) || (md.op == MD_DIV);
   assign is_div    = (md.op == MD_DIV) || (md.op == MD_DIVU);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opd_d   = opd_q;
      rs_d    = rs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      done_d  = 1'b0;
      unique case (state_q)
         MD_IDLE: begin
            if (md.start) begin
               unique case (md.op)
                  MD_MTHI: hi_d = md.rs_data;
                  MD_MTLO: lo_d = md.rs_data;
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                     logic [31:0] a, b;
                     a = is_signed ? md_abs(md.rs_data) : md.rs_data;
                     b = is_signed ? md_abs(md.rt_data) : md.rt_data;
                     state_d = MD_CALC;
                     cnt_d   = 5'd0;
                     div_d   = is_div;
                     rs_d    = md.rs_data;
                     dz_d    = is_div && (md.rt_data == 32'd0);
                     neg_d   = is_signed
                             && (md.rs_data[31] ^ md.rt_data[31]);
                     rneg_d  = is_signed && md.rs_data[31];
                     acc_d   = {32'd0, is_div ? a : b};
                     opd_d   = is_div ? b : a;
                  end
                  default: ;
               endcase
            end
         end
         MD_CALC: begin
            acc_d = div_q ? div_nxt : mul_nxt;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(MD_ITERS - 1)) begin
               state_d = MD_FIX;
               cnt_d   = 5'd0;
            end
         end
         MD_FIX: begin
            state_d = MD_IDLE;
            done_d  = 1'b1;
            if (!div_q) begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end else if (dz_q) begin
               hi_d = rs_q;
               lo_d = 32'hFFFF_FFFF;
            end else begin
               lo_d = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
               hi_d = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opd_q   <= '0;
         rs_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opd_q   <= opd_d;
         rs_q    <= rs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         done_q  <= done_d;
      end
   end

   assign md.busy    = (state_q != MD_IDLE);
   assign md.done    = done_q;
   assign md.HI_data = hi_q;
   assign md.LO_data = lo_q;

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit that owns the HI and LO registers of the multi-cycle MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO under controller handshake. Its `HI_data`/`LO_data` outputs feed the HI and LO inputs of the general-register write-data multiplexer, which serves MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.

Ports:
- `clk`  in  1  core clock, rising-edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  request strobe, sampled only in IDLE.
- `op`  in  3  operation code, sampled with `start`.
- `rs_data`  in  32  multiplicand / dividend / MTHI-MTLO source.
- `rt_data`  in  32  multiplier / divisor.
- `busy`  out  1  high while an arithmetic op is in progress.
- `done`  out  1  one-cycle pulse when HI/LO receive an arithmetic result.
- `HI_data`  out  32  HI register contents.
- `LO_data`  out  32  LO register contents.

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6. Code 7 is treated as NONE.
- Reset values: `HI_data`=0, `LO_data`=0, `busy`=0, `done`=0, state IDLE, iteration counter 0.
- States: IDLE, CALC, FIX.
- **IDLE:**
  - `start` with MTHI writes HI←`rs_data` at that edge; MTLO writes LO←`rs_data`. Both are single-cycle; `busy` and `done` stay 0.
  - `start` with MULT/MULTU/DIV/DIVU latches the operands and goes to CALC with counter=0.
  - `start` with NONE/7 is ignored.
- **Operand conditioning:**
  - Signed ops (MULT, DIV) latch magnitudes and record the result signs.
  - Multiply sign = sign(rs) XOR sign(rt).
  - Quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - The magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- **CALC:** one iteration per cycle, 32 iterations (counter 0..31). After counter=31 the state goes to FIX.
  - Multiply: radix-2 shift-add into a 64-bit product.
  - Divide: restoring, one quotient bit per cycle, 33-bit partial remainder.
- **FIX:**
  - Applies two's-complement negation where the recorded sign is 1.
  - Writes HI/LO: multiply gives HI=product[63:32], LO=product[31:0]; divide gives LO=quotient, HI=remainder.
  - Asserts `done` for one cycle and returns to IDLE.
- **Divide by zero** (DIV or DIVU with `rt_data`=0) runs the full latency, then sets LO=0xFFFFFFFF and HI=`rs_data` as latched.
- **DIV 0x80000000 / 0xFFFFFFFF** gives LO=0x80000000, HI=0 (natural wrap, no trap).
- All arithmetic is modulo 2^32 per half; there are no overflow flags.

## Timing
- `busy` = (state ≠ IDLE), driven from registered state.
- An arithmetic op accepted at edge E0 holds `busy` high for the 33 cycles after E0 (32 CALC + 1 FIX).
- At edge E33, HI/LO update and `done`=1 for exactly the cycle following E33; `busy`=0 in that same cycle.
- A new `start` may be accepted at E34, or at E33 itself if it is sampled while the state is FIX→IDLE. It is not: `start` is honoured only when the current state is IDLE.
- `start` while `busy`=1 is ignored, with no queuing. HI/LO keep their old values until FIX.
- MTHI/MTLO take effect at the accepting edge; new values are visible in the next cycle.
- `rst` asserted in any state (including mid-CALC) returns everything to reset values at that edge. No `done` is emitted for the aborted op.
- `rst` and `start` together: reset wins.
- `HI_data`/`LO_data` are stable register outputs with no combinational path from inputs.

## Structure
- Shared package holds:
  - op-code constants: `MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`;
  - state encodings: `MD_IDLE`, `MD_CALC`, `MD_FIX`;
  - the iteration count 32.
- Single module; no sub-module required. The shift-add and restore steps share the 64-bit working register {rem/prod-hi, quot/prod-lo}.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles, `done` pulse; HI=0xFFFFFFFE, LO=0x00000001.
- **MULT:** −3 (0xFFFFFFFD) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **DIV:**
  - −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **DIVU by zero:** 0x12345678 / 0 → LO=0xFFFFFFFF, HI=0x12345678.
- **MTHI/MTLO and busy rejection:**
  - MTHI 0xDEADBEEF then MTLO 0xCAFEBABE on consecutive cycles → next cycle HI=0xDEADBEEF, LO=0xCAFEBABE, `busy` never set.
  - `start` MULT while busy → ignored; the first result is unchanged.
- **Reset mid-CALC:** assert `rst` at iteration 10 of a DIVU → next cycle `busy`=0, HI=LO=0, no `done`. A following MULTU 6×7 gives LO=42.
